morse_code_transmitter: RTL and testbench
=========================================

Name: morse_code_transmitter

Overview:
- Serialises one Morse letter, given as a symbol pattern and a symbol count, into timed on/off pulses on a single LED.
- Sits directly downstream of the letter/length decoder: consumes its letter[3:0] and length[2:0] outputs and drives LEDR[0].
- A start pulse from the debounced KEY[1] path launches transmission.
- Timing is based on one Morse unit, which defaults to 0.5 s at 50 MHz.

Parameters:
- TICKS_PER_UNIT, 25000000: CLOCK_50 cycles per Morse unit. Must be >= 2.
- CNT_W, 25: width of the unit tick counter. Must hold TICKS_PER_UNIT-1.

Ports:
- CLOCK_50  in  1  system clock (50 MHz). All state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- start  in  1  single-cycle or level request. Sampled only in IDLE.
- letter  in  4  symbol pattern; bit i = symbol i; 1 = dash, 0 = dot; bit 0 sent first.
- length  in  3  number of symbols to send, 0..4.
- led  out  1  Morse output; 1 = lamp on.
- busy  out  1  high while a letter is in progress, i.e. in any state other than IDLE.
- done  out  1  one-cycle pulse when a letter completes.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; led=0, busy=0, done=0; shift register, symbol counter and tick counter cleared. Reset mid-transmission aborts immediately; no done pulse.
- States: IDLE, MARK, SPACE.
- IDLE:
  - led=0, busy=0.
  - If start=1 and length in 1..4: latch letter into sym_sr[3:0] and length into rem[2:0], clear tick counter, load units = (letter[0] ? 3 : 1). Next state MARK.
  - If start=1 and length=0: no transmission. done=1 on the next cycle; state stays IDLE.
  - If start=1 and length>4: treated as 4.
- MARK:
  - led=1, busy=1.
  - Tick counter increments each cycle. At TICKS_PER_UNIT-1 it wraps to 0 and units decrements.
  - When units=1 and the tick counter wraps:
    - If rem>1: shift sym_sr right by 1, rem-=1, next state SPACE.
    - Else: next state IDLE, with done=1 during that first IDLE cycle.
  - A dot holds led high for exactly 1*TICKS_PER_UNIT cycles; a dash for exactly 3*TICKS_PER_UNIT cycles.
- SPACE:
  - led=0, busy=1, for exactly TICKS_PER_UNIT cycles (intra-letter gap = 1 unit).
  - On wrap: load units = (sym_sr[0] ? 3 : 1), next state MARK.
- No trailing gap after the last symbol; inter-letter spacing is the upstream controller's job.
- start is ignored while busy=1; letter and length may change freely during transmission (latched copy used).
- start held high across done: a new transmission begins in the cycle after done. Back-to-back letters have no gap.
- The first led=1 cycle is the cycle after start is sampled (1-cycle latency).
- Outputs are registered and come directly from state and registers; no combinational path from inputs to outputs.

Test Plan (TICKS_PER_UNIT=4):
- Letter A: letter=0010, length=2, start pulse -> led high 4 cycles, low 4, high 12, then done=1 for 1 cycle; busy high for 20 cycles.
- Letter H: letter=0000, length=4 -> four 4-cycle marks separated by three 4-cycle spaces (28 cycles busy), then one done pulse.
- Letter G: letter=0011, length=3 -> marks of 12, 12 and 4 cycles with 4-cycle spaces; done after 36 busy cycles.
- length=0 with start -> led stays 0, busy stays 0, done=1 exactly one cycle later.
- start re-pulsed mid-letter B (0001, length 4) -> ignored; waveform identical to an undisturbed B (dash, dot, dot, dot; 36 cycles).
- resetn asserted during second mark of A -> led=0 and busy=0 immediately (asynchronous), no done; a fresh start afterwards sends a complete A.

Source files
------------

// File: rtl/morse_code_transmitter.sv
// Serialises one Morse letter (dot/dash pattern plus symbol count) into timed
// LED pulses; one Morse unit lasts TICKS_PER_UNIT clock cycles.
module morse_code_transmitter #(
  parameter int TICKS_PER_UNIT = 25000000,
  parameter int CNT_W          = 25
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] letter,
  input  logic [2:0] length,
  output logic       led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] TICK_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [3:0]       sym_sr_r, sym_sr_s;
  logic [2:0]       rem_r, rem_s;
  logic [1:0]       units_r, units_s;
  logic [CNT_W-1:0] tick_r, tick_s;
  logic             led_r, led_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // State, datapath and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      sym_sr_r <= 4'd0;
      rem_r    <= 3'd0;
      units_r  <= 2'd0;
      tick_r   <= TICK_ZERO;
      led_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      sym_sr_r <= sym_sr_s;
      rem_r    <= rem_s;
      units_r  <= units_s;
      tick_r   <= tick_s;
      led_r    <= led_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state
  // so the registered copies line up with the state register.
  always_comb begin
    state_s  = state_r;
    sym_sr_s = sym_sr_r;
    rem_s    = rem_r;
    units_s  = units_r;
    tick_s   = tick_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        tick_s = TICK_ZERO;
        if (start) begin
          if (length == 3'd0) begin
            done_s = 1'b1;
          end else begin
            sym_sr_s = letter;
            rem_s    = (length > 3'd4) ? 3'd4 : length;
            units_s  = letter[0] ? 2'd3 : 2'd1;
            state_s  = MARK;
          end
        end else begin
          done_s = 1'b0;
        end
      end
      MARK: begin
        if (tick_r == TICK_LAST) begin
          tick_s = TICK_ZERO;
          if (units_r == 2'd1) begin
            if (rem_r > 3'd1) begin
              sym_sr_s = {1'b0, sym_sr_r[3:1]};
              rem_s    = rem_r - 3'd1;
              state_s  = SPACE;
            end else begin
              state_s = IDLE;
              done_s  = 1'b1;
            end
          end else begin
            units_s = units_r - 2'd1;
          end
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      SPACE: begin
        if (tick_r == TICK_LAST) begin
          tick_s  = TICK_ZERO;
          units_s = sym_sr_r[0] ? 2'd3 : 2'd1;
          state_s = MARK;
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    led_s  = (state_s == MARK);
    busy_s = (state_s != IDLE);
  end

  assign led  = led_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_morse_code_transmitter.sv
// Directed bench for morse_code_transmitter with TICKS_PER_UNIT=4: captures
// per-cycle led/busy/done traces and compares them with hand-built patterns.
module tb_morse_code_transmitter;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [3:0] letter;
  logic [2:0] length;
  logic       led;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  logic [47:0] led_t, busy_t, done_t;

  morse_code_transmitter #(.TICKS_PER_UNIT(4), .CNT_W(2)) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .start   (start),
    .letter  (letter),
    .length  (length),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: pulse start for one edge, then record 48 cycles.
  // Bit i of each trace is the output value i cycles after start was sampled.
  task automatic run(input logic [3:0] l, input logic [2:0] n, input int repulse,
                     output logic [47:0] lt, output logic [47:0] bt, output logic [47:0] dt);
    letter = l;
    length = n;
    start  = 1'b1;
    lt = '0; bt = '0; dt = '0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      lt[i] = led;
      bt[i] = busy;
      dt[i] = done;
      if (i == repulse) begin
        start  = 1'b1;
        letter = 4'hF;
        length = 3'd1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    resetn = 1'b0;
    start  = 1'b0;
    letter = 4'd0;
    length = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_led", {47'd0, led}, 48'd0);
    check("reset_busy", {47'd0, busy}, 48'd0);
    check("reset_done", {47'd0, done}, 48'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Letter A: dot, dash
    run(4'b0010, 3'd2, -1, led_t, busy_t, done_t);
    check("A_led", led_t, 48'hFFF0F);
    check("A_busy", busy_t, 48'hFFFFF);
    check("A_done", done_t, 48'h1 << 20);

    // Letter H: four dots
    run(4'b0000, 3'd4, -1, led_t, busy_t, done_t);
    check("H_led", led_t, 48'hF0F0F0F);
    check("H_busy", busy_t, 48'hFFFFFFF);
    check("H_done", done_t, 48'h1 << 28);

    // length above 4 is clamped to 4
    run(4'b0000, 3'd7, -1, led_t, busy_t, done_t);
    check("len7_led", led_t, 48'hF0F0F0F);
    check("len7_busy", busy_t, 48'hFFFFFFF);
    check("len7_done", done_t, 48'h1 << 28);

    // Letter G: dash, dash, dot
    run(4'b0011, 3'd3, -1, led_t, busy_t, done_t);
    check("G_led", led_t, 48'hF0FFF0FFF);
    check("G_busy", busy_t, 48'hFFFFFFFFF);
    check("G_done", done_t, 48'h1 << 36);

    // length 0: no transmission, done one cycle after start
    run(4'b0101, 3'd0, -1, led_t, busy_t, done_t);
    check("len0_led", led_t, 48'h0);
    check("len0_busy", busy_t, 48'h0);
    check("len0_done", done_t, 48'h1);

    // Letter B with start re-pulsed (and inputs disturbed) mid-letter
    run(4'b0001, 3'd4, 14, led_t, busy_t, done_t);
    check("B_led", led_t, 48'hF0F0F0FFF);
    check("B_busy", busy_t, 48'hFFFFFFFFF);
    check("B_done", done_t, 48'h1 << 36);

    // Reset during the second mark of A
    letter = 4'b0010;
    length = 3'd2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midA_led_before_reset", {47'd0, led}, 48'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_async_led", {47'd0, led}, 48'd0);
    check("rst_async_busy", {47'd0, busy}, 48'd0);
    done_t = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done_t[i] = done;
    end
    resetn = 1'b1;
    for (int i = 4; i < 16; i++) begin
      @(negedge clk);
      done_t[i] = done;
    end
    check("rst_no_done", done_t, 48'h0);
    check("rst_idle_busy", {47'd0, busy}, 48'd0);

    // Fresh A after the abort
    run(4'b0010, 3'd2, -1, led_t, busy_t, done_t);
    check("A2_led", led_t, 48'hFFF0F);
    check("A2_busy", busy_t, 48'hFFFFF);
    check("A2_done", done_t, 48'h1 << 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
